fetch_req_ctrl: RTL

Fetch-side request controller sitting between the IF pipeline stage and the instruction port of the SRAM-like-to-AXI bridge. It generates word fetch requests from a local PC, holds each request stable until `inst_sram_addr_ok`, and captures the matching `inst_sram_data_ok` word into a one-entry output buffer for the ID stage. Redirects (branch/exception flush) cancel the request already in flight by discarding its returning data. At most one request is outstanding at any time, matching the bridge's single instruction ID.

---
 rtl/fetch_req_ctrl_pkg.sv | 18 +
 rtl/fetch_req_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fetch_req_ctrl_pkg.sv
// Shared fetch-side definitions: FSM encoding, reset PC, transfer size and
// the sequential fetch address step.
package fetch_req_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;
    localparam logic [1:0]  SIZE_WORD        = 2'b10;

    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_req_ctrl.sv
// IF-stage request controller: one outstanding word fetch on the SRAM-like
// instruction port, redirect via a discard flag, one-entry buffer toward ID.
module fetch_req_ctrl
    import fetch_req_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        id_allowin,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic         req_q, req_d;
    logic         discard_q, discard_d;
    logic         valid_q, valid_d;
    logic [31:0]  fs_pc_q, fs_pc_d;
    logic [31:0]  fs_inst_q, fs_inst_d;
    logic         load_s;

    // Next-state logic for the request FSM, fetch PC and output buffer.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        discard_d  = discard_q;
        valid_d    = valid_q;
        fs_pc_d    = fs_pc_q;
        fs_inst_d  = fs_inst_q;
        load_s     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!valid_q || id_allowin) begin
                    state_d    = S_REQ;
                    req_addr_d = flush ? flush_pc : pc_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                // A request already marked stale must not advance pc past the redirect target.
                if (inst_sram_addr_ok) begin
                    state_d = S_WAIT;
                    if (!discard_q) begin
                        pc_d = next_word_addr(req_addr_q);
                    end else begin
                        pc_d = pc_q;
                    end
                end else begin
                    state_d = S_REQ;
                end
                discard_d = discard_q | flush;
            end
            S_WAIT: begin
                if (inst_sram_data_ok) begin
                    state_d = S_REQ;
                    if (discard_q) begin
                        discard_d  = 1'b0;
                        req_addr_d = flush ? flush_pc : pc_q;
                    end else if (flush) begin
                        req_addr_d = flush_pc;
                    end else begin
                        load_s  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    discard_d = discard_q | flush;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            pc_d = flush_pc;
        end else begin
            pc_d = pc_d;
        end

        if (load_s) begin
            valid_d   = 1'b1;
            fs_pc_d   = req_addr_q;
            fs_inst_d = inst_sram_rdata;
        end else if (flush || (id_allowin && valid_q)) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        req_d = (state_d == S_REQ);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            req_q      <= 1'b0;
            discard_q  <= 1'b0;
            valid_q    <= 1'b0;
            fs_pc_q    <= 32'h0000_0000;
            fs_inst_q  <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            req_q      <= req_d;
            discard_q  <= discard_d;
            valid_q    <= valid_d;
            fs_pc_q    <= fs_pc_d;
            fs_inst_q  <= fs_inst_d;
        end
    end

    assign inst_sram_req   = req_q;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = SIZE_WORD;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_addr  = req_addr_q;
    assign inst_sram_wdata = 32'h0000_0000;
    assign fs_to_ds_valid  = valid_q;
    assign fs_pc           = fs_pc_q;
    assign fs_inst         = fs_inst_q;

endmodule
